// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

   // Converter FSM state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest legal value of one BCD digit
   localparam int unsigned BCD_MAX = 9;

   // Minimum result width able to hold any DIGITS-digit decimal value
   function automatic int unsigned bin_width(input int unsigned digits);
      longint unsigned range_v;
      int unsigned     w;
      range_v = 64'd1;
      w       = 0;
      for (int unsigned i = 0; i < digits; i++) begin
         range_v = range_v * 64'd10;
      end
      while ((64'd1 << w) < range_v) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal accumulate step: acc_out = acc_in*10 + digit.
module bcd_mac_step #(
   parameter int unsigned BIN_W = 14
) (
   input  logic [BIN_W-1:0] acc_in,
   input  logic [3:0]       digit,
   output logic [BIN_W-1:0] acc_out
);

   // times ten as shift-and-add, then add the incoming digit
   assign acc_out = (acc_in << 3) + (acc_in << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: MSD first, one digit per clock,
// valid/ready on both sides, registered outputs.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [4*DIGITS-1:0]   bcd_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [BIN_W-1:0]      number_o,
   output logic                  error_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(DIGITS + 1);

   // Elaboration-time legality of the parameter set
   if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
      $error("bcd_to_bin_seq: DIGITS must be in 1..9");
   end
   if (BIN_W < bin_width(DIGITS)) begin : g_bad_width
      $error("bcd_to_bin_seq: BIN_W too narrow for DIGITS");
   end

   state_t             state;
   logic [BIN_W-1:0]   acc;
   logic [BIN_W-1:0]   acc_next_c;
   logic [BCD_W-1:0]   dig_sr;
   logic [CNT_W-1:0]   cnt;
   logic               err;
   logic               in_err_c;
   logic [3:0]         top_digit_c;

   assign top_digit_c = dig_sr[BCD_W-1 -: 4];

   // Flag any digit of the incoming word above BCD_MAX
   always_comb begin
      in_err_c = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_i[4*i +: 4] > 4'(BCD_MAX)) begin
            in_err_c = 1'b1;
         end
      end
   end

   bcd_mac_step #(
      .BIN_W (BIN_W)
   ) u_mac (
      .acc_in  (acc),
      .digit   (top_digit_c),
      .acc_out (acc_next_c)
   );

   // FSM, datapath registers and registered handshake/result outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= IDLE;
         acc      <= '0;
         dig_sr   <= '0;
         cnt      <= '0;
         err      <= 1'b0;
         ready_o  <= 1'b1;
         valid_o  <= 1'b0;
         number_o <= '0;
         error_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i && ready_o) begin
                  dig_sr  <= bcd_i;
                  acc     <= '0;
                  cnt     <= CNT_W'(DIGITS);
                  err     <= in_err_c;
                  ready_o <= 1'b0;
                  state   <= CONV;
               end
            end
            CONV: begin
               acc    <= acc_next_c;
               dig_sr <= dig_sr << 4;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state    <= DONE;
                  valid_o  <= 1'b1;
                  number_o <= err ? '0 : acc_next_c;
                  error_o  <= err;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state    <= IDLE;
                  valid_o  <= 1'b0;
                  ready_o  <= 1'b1;
                  number_o <= '0;
                  error_o  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               ready_o <= 1'b1;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (4-digit main instance, 2-digit sweep instance).
module tb_bcd_to_bin_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn_i;
   logic [15:0] bcd_i;
   logic        valid_i, ready_i;
   logic        ready_o, valid_o, error_o;
   logic [13:0] number_o;

   logic [7:0]  b_bcd;
   logic        b_valid, b_rdy_in;
   logic        b_ready_o, b_valid_o, b_error;
   logic [6:0]  b_num;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
      .clk_i    (clk),
      .rstn_i   (rstn_i),
      .bcd_i    (bcd_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .number_o (number_o),
      .error_o  (error_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i)
   );

   bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
      .clk_i    (clk),
      .rstn_i   (rstn_i),
      .bcd_i    (b_bcd),
      .valid_i  (b_valid),
      .ready_o  (b_ready_o),
      .number_o (b_num),
      .error_o  (b_error),
      .valid_o  (b_valid_o),
      .ready_i  (b_rdy_in)
   );

   typedef struct {
      logic [15:0] bcd;
      int          num;
      logic        err;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: positional decimal weighting, least significant digit first
   function automatic void ref_model(input logic [31:0] bcd, input int digits,
                                     output longint val, output logic err);
      longint w;
      int     d;
      w   = 1;
      val = 0;
      err = 1'b0;
      for (int i = 0; i < digits; i++) begin
         d = int'((bcd >> (4 * i)) & 32'hF);
         if (d > 9) err = 1'b1;
         val = val + longint'(d) * w;
         w   = w * 10;
      end
      if (err) val = 0;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Called #1 after a rising edge with the main DUT idle
   task automatic do_conv(input logic [15:0] bcd, output logic [13:0] num,
                          output logic err, output int lat);
      bcd_i   = bcd;
      valid_i = 1'b1;
      ready_i = 1'b0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = 0;
      while (!valid_o && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!valid_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL conv_timeout: got valid_o=0, expected valid_o=1 within 20 cycles");
      end
      num = number_o;
      err = error_o;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
   endtask

   task automatic do_conv2(input logic [7:0] bcd, output logic [6:0] num,
                           output logic err);
      int lat;
      b_bcd   = bcd;
      b_valid = 1'b1;
      @(posedge clk); #1;
      b_valid = 1'b0;
      lat = 0;
      while (!b_valid_o && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!b_valid_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL sweep_timeout: got valid_o=0, expected valid_o=1 within 10 cycles");
      end
      num = b_num;
      err = b_error;
      b_rdy_in = 1'b1;
      @(posedge clk); #1;
      b_rdy_in = 1'b0;
   endtask

   logic [13:0] r_num;
   logic        r_err;
   int          r_lat;
   logic [6:0]  s_num;
   logic        s_err;
   longint      m_val;
   logic        m_err;
   logic [15:0] rnd;
   logic        acc_now;
   int          k, got, last, cyc;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h0000,    0, 1'b0};
      vecs[1] = '{16'h1234, 1234, 1'b0};
      vecs[2] = '{16'h9999, 9999, 1'b0};
      vecs[3] = '{16'h0907,  907, 1'b0};
      vecs[4] = '{16'h12A4,    0, 1'b1};
      vecs[5] = '{16'hF001,    0, 1'b1};
      vecs[6] = '{16'h9999, 9999, 1'b0};
      vecs[7] = '{16'h0042,   42, 1'b0};

      rstn_i = 1'b0; bcd_i = '0; valid_i = 1'b0; ready_i = 1'b0;
      b_bcd = '0; b_valid = 1'b0; b_rdy_in = 1'b0;
      #12;
      check("reset_ready", ready_o, 1);
      check("reset_valid", valid_o, 0);
      check("reset_number", number_o, 0);
      check("reset_error", error_o, 0);
      rstn_i = 1'b1;
      @(posedge clk); #1;

      // Table of fixed vectors, including error then valid back-to-back
      for (int i = 0; i < 8; i++) begin
         do_conv(vecs[i].bcd, r_num, r_err, r_lat);
         check($sformatf("vec%0d_number", i), r_num, vecs[i].num);
         check($sformatf("vec%0d_error", i), r_err, vecs[i].err);
         check($sformatf("vec%0d_latency", i), r_lat, 4);
         check($sformatf("vec%0d_valid_after", i), valid_o, 0);
         check($sformatf("vec%0d_ready_after", i), ready_o, 1);
      end

      // Asynchronous reset in the middle of a conversion
      bcd_i = 16'h1234; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #2;
      rstn_i = 1'b0;
      #1;
      check("midreset_ready", ready_o, 1);
      check("midreset_valid", valid_o, 0);
      check("midreset_number", number_o, 0);
      check("midreset_error", error_o, 0);
      @(posedge clk); #1;
      rstn_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("midreset_discard", valid_o, 0);
      end
      do_conv(16'h0042, r_num, r_err, r_lat);
      check("post_reset_number", r_num, 42);
      check("post_reset_error", r_err, 0);

      // Backpressure in DONE, with an ignored valid_i pulse
      bcd_i = 16'h1234; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", valid_o, 1);
         check("bp_number", number_o, 1234);
         check("bp_error", error_o, 0);
         check("bp_ready", ready_o, 0);
         bcd_i   = 16'h5555;
         valid_i = (i == 2);
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_number", number_o, 1234);
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check("bp_release_valid", valid_o, 0);
      check("bp_release_ready", ready_o, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("bp_pulse_ignored", valid_o, 0);
      end

      // Streaming with both handshakes held high
      k = 1; got = 0; last = -1; cyc = 0;
      bcd_i = to_bcd(1); valid_i = 1'b1; ready_i = 1'b1;
      while (got < 5 && cyc < 100) begin
         acc_now = ready_o && valid_i;
         if (valid_o) begin
            check("stream_value", number_o, got + 1);
            if (got > 0) check("stream_spacing", cyc - last, 6);
            last = cyc;
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            k++;
            bcd_i = to_bcd(k);
         end
      end
      check("stream_count", got, 5);
      valid_i = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      ready_i = 1'b0;

      // Random vectors against the reference model
      for (int n = 0; n < 40; n++) begin
         for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 7) == 0) rnd[4*d +: 4] = 4'($urandom_range(10, 15));
            else                           rnd[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         ref_model({16'h0, rnd}, 4, m_val, m_err);
         do_conv(rnd, r_num, r_err, r_lat);
         check($sformatf("rand_%h_number", rnd), r_num, m_val);
         check($sformatf("rand_%h_error", rnd), r_err, m_err);
      end

      // Exhaustive 2-digit sweep
      for (int c = 0; c < 256; c++) begin
         ref_model(32'(c), 2, m_val, m_err);
         do_conv2(8'(c), s_num, s_err);
         check($sformatf("sweep_%h_number", c), s_num, m_val);
         check($sformatf("sweep_%h_error", c), s_err, m_err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
